// File: rtl/fpga_template_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fpga_template_pkg
//  Description : Shared types for the frame peak detector (FSM state encoding)
//  Revision    : 1.0 - initial release
// ============================================================================
package fpga_template_pkg;

   // Detector control states: waiting for a frame, accumulating, presenting result
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_RESULT  = 2'd2
   } fpd_state_t;

endpackage : fpga_template_pkg
`default_nettype wire

// File: rtl/frame_peak_detector.sv
`default_nettype none
// ============================================================================
//  Module      : frame_peak_detector
//  Description : Per-frame peak |sample|, its first index and the sum of
//                |sample| over a DEPTH-sample frame, with a valid/ready result
//  Revision    : 1.0 - initial release
// ============================================================================
module frame_peak_detector #(
   parameter int WIDTH      = 32,
   parameter int DEPTH      = 16,
   parameter int ADDR_WIDTH = $clog2(DEPTH),
   parameter int ACC_WIDTH  = WIDTH + ADDR_WIDTH
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  frame_start_i,
   input  logic [WIDTH-1:0]      sample_data_i,
   input  logic                  sample_valid_i,
   output logic                  sample_ready_o,
   output logic                  result_valid_o,
   input  logic                  result_ready_i,
   output logic [WIDTH-1:0]      peak_abs_o,
   output logic [ADDR_WIDTH-1:0] peak_index_o,
   output logic [ACC_WIDTH-1:0]  abs_sum_o,
   output logic                  frame_error_o
);
   import fpga_template_pkg::*;

   localparam logic [ADDR_WIDTH-1:0] C_LAST_INDEX = ADDR_WIDTH'(DEPTH - 1);

   fpd_state_t            state, next_state;
   logic [ADDR_WIDTH-1:0] count, next_count;
   logic [WIDTH-1:0]      peak, next_peak;
   logic [ADDR_WIDTH-1:0] peak_idx, next_idx;
   logic [ACC_WIDTH-1:0]  sum, next_sum;
   logic [WIDTH-1:0]      abs_val;
   logic                  clear_acc;
   logic                  xfer;
   logic                  load_result;
   logic                  next_error;

   // The result is valid exactly while the FSM sits in RESULT
   assign result_valid_o = (state == ST_RESULT);

   // Next-state, accumulator update and handshake decode
   always_comb begin
      next_state     = state;
      next_count     = count;
      next_peak      = peak;
      next_idx       = peak_idx;
      next_sum       = sum;
      sample_ready_o = 1'b0;
      clear_acc      = 1'b0;
      next_error     = 1'b0;
      load_result    = 1'b0;
      xfer           = 1'b0;
      // Two's-complement negate in WIDTH bits: the most-negative value maps to
      // 2^(WIDTH-1), which is representable as unsigned WIDTH bits.
      abs_val        = sample_data_i[WIDTH-1] ? (~sample_data_i + 1'b1) : sample_data_i;

      case (state)
         ST_IDLE: begin
            sample_ready_o = frame_start_i;
            if (frame_start_i) begin
               clear_acc  = 1'b1;
               next_state = ST_COLLECT;
            end
         end
         ST_COLLECT: begin
            sample_ready_o = 1'b1;
            // A new frame_start aborts the partial frame and restarts at index 0
            if (frame_start_i) begin
               clear_acc  = 1'b1;
               next_error = 1'b1;
            end
         end
         ST_RESULT: begin
            // Incoming frame is dropped; the held result is untouched
            if (frame_start_i) begin
               next_error = 1'b1;
            end
            if (result_ready_i) begin
               next_state = ST_IDLE;
            end
         end
         default: begin
            next_state = ST_IDLE;
         end
      endcase

      if (clear_acc) begin
         next_count = '0;
         next_peak  = '0;
         next_idx   = '0;
         next_sum   = '0;
      end

      xfer = sample_valid_i && sample_ready_o;
      if (xfer) begin
         next_sum = next_sum + ACC_WIDTH'(abs_val);
         // Strict compare so the first sample reaching the peak keeps the index
         if (abs_val > next_peak) begin
            next_peak = abs_val;
            next_idx  = next_count;
         end
         if (next_count == C_LAST_INDEX) begin
            next_state  = ST_RESULT;
            load_result = 1'b1;
         end
         next_count = next_count + 1'b1;
      end
   end

   // State, accumulators and result registers
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state         <= ST_IDLE;
         count         <= '0;
         peak          <= '0;
         peak_idx      <= '0;
         sum           <= '0;
         peak_abs_o    <= '0;
         peak_index_o  <= '0;
         abs_sum_o     <= '0;
         frame_error_o <= 1'b0;
      end else begin
         state         <= next_state;
         count         <= next_count;
         peak          <= next_peak;
         peak_idx      <= next_idx;
         sum           <= next_sum;
         frame_error_o <= next_error;
         if (load_result) begin
            peak_abs_o   <= next_peak;
            peak_index_o <= next_idx;
            abs_sum_o    <= next_sum;
         end
      end
   end

endmodule : frame_peak_detector
`default_nettype wire
